uart_rx_cfg: RTL and testbench

Parametrised UART receiver: next generation of the team's fixed 8N1 serial receiver.
- Adds configurable data width, parity, stop-bit count, a din synchroniser, start-bit glitch rejection, and per-frame parity/framing error flags.
- Sits between the board RX pin and the APB-side receive register/FIFO, delivering one word per frame with a single-cycle valid strobe.

---
 rtl/uart_rx_cfg.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg -- parametrised UART receiver (start, DATA_BITS data LSB first,
// optional even/odd parity, 1 or 2 stop bits).
//
// Ports:
//   clk, rst    system clock; asynchronous active-high reset
//   din         serial line (idle high), asynchronous to clk
//   dout        last received word
//   valid       one-cycle strobe: dout and flags updated
//   parity_err  parity mismatch in last frame (never set when PARITY_MODE = 0)
//   frame_err   a stop bit was sampled low in last frame
//   busy        high while a frame is in progress (START..WAIT_HIGH)
//   break_det   break flag for last frame
//
// Optional feature: define UART_RX_BREAK_DETECT_EN to register break_det,
// set when start, every data bit, the parity bit (if any) and the first stop
// bit all sampled low. Undefined, break_det is tied to 0.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 50,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    output logic [DATA_BITS-1:0] dout,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy,
    output logic                 break_det
);

    localparam int N  = DATA_BITS + ((PARITY_MODE != 0) ? 1 : 0) + STOP_BITS;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(N + 1);

    localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY_MODE == 2);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] PARITY    = 3'd3;
    localparam logic [2:0] STOP      = 3'd4;
    localparam logic [2:0] WAIT_HIGH = 3'd5;

    logic                 sync1, din_s;
    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] sr;
    logic                 pe_acc, fe_acc;
    logic                 tick, last_stop;

    // START waits half a bit to land mid-bit; every later bit is a full bit on.
    assign tick      = (state == START) ? (cnt == HALF_M1) : (cnt == FULL_M1);
    assign last_stop = (state == STOP) && tick && (idx == STOP_LAST);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1      <= 1'b1;
            din_s      <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            sr         <= '0;
            pe_acc     <= 1'b0;
            fe_acc     <= 1'b0;
            dout       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync1 <= din;
            din_s <= sync1;
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (!din_s) state <= START;
                end
                START: begin
                    if (tick) begin
                        cnt <= '0;
                        if (din_s) begin
                            state <= IDLE;          // glitch, not a start bit
                        end else begin
                            state  <= DATA;
                            pe_acc <= 1'b0;
                            fe_acc <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (tick) begin
                        cnt <= '0;
                        sr  <= {din_s, sr[DATA_BITS-1:1]};   // LSB arrives first
                        if (idx == DATA_LAST) begin
                            idx   <= '0;
                            state <= (PARITY_MODE != 0) ? PARITY : STOP;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PARITY: begin
                    if (tick) begin
                        cnt    <= '0;
                        // even: error when XOR of data+parity is 1; odd: when 0
                        pe_acc <= (^sr) ^ din_s ^ ODD;
                        state  <= STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (tick) begin
                        cnt <= '0;
                        if (last_stop) begin
                            idx        <= '0;
                            dout       <= sr;
                            parity_err <= pe_acc;
                            frame_err  <= fe_acc | ~din_s;
                            valid      <= 1'b1;
                            // leave mid-stop so a start half a bit later is caught
                            state      <= din_s ? IDLE : WAIT_HIGH;
                        end else begin
                            idx    <= idx + IW'(1);
                            fe_acc <= fe_acc | ~din_s;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_HIGH: begin
                    // a held-low line must not look like a fresh start edge
                    if (din_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    logic brk_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            brk_acc   <= 1'b0;
            break_det <= 1'b0;
        end else if (tick) begin
            case (state)
                START:        brk_acc <= ~din_s;
                DATA, PARITY: brk_acc <= brk_acc & ~din_s;
                STOP: begin
                    if (idx == '0) brk_acc <= brk_acc & ~din_s;
                    // with one stop bit the first stop is the final sample
                    if (last_stop) break_det <= brk_acc & ((idx != '0) | ~din_s);
                end
                default: brk_acc <= brk_acc;
            endcase
        end
    end
`else
    assign break_det = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: instance a uses defaults (8N1, 50 clk/bit),
// instance b is 7E2 at 16 clk/bit. Inputs change on negedges; cyc counts
// posedges. If din is first driven at a negedge where cyc == c, the line is
// seen by the state machine at posedge c+3 (two sync flops), so the final
// stop sample lands at posedge c+3+H+N*CPB and valid is seen at the
// following negedge with cyc == c+3+H+N*CPB.
//   a: 3+25+9*50  = 478      b: 3+8+10*16 = 171
module tb_uart_rx_cfg;

    logic       clk = 1'b0;
    logic       rst;
    logic       din_a, din_b;
    logic [7:0] dout_a;
    logic [6:0] dout_b;
    logic       valid_a, pe_a, fe_a, busy_a, brk_a;
    logic       valid_b, pe_b, fe_b, busy_b, brk_b;

    localparam logic EXP_BRK =
`ifdef UART_RX_BREAK_DETECT_EN
        1'b1;
`else
        1'b0;
`endif

    uart_rx_cfg u_a (
        .clk(clk), .rst(rst), .din(din_a), .dout(dout_a), .valid(valid_a),
        .parity_err(pe_a), .frame_err(fe_a), .busy(busy_a), .break_det(brk_a)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) u_b (
        .clk(clk), .rst(rst), .din(din_b), .dout(dout_b), .valid(valid_b),
        .parity_err(pe_b), .frame_err(fe_b), .busy(busy_b), .break_det(brk_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // valid monitors: count every strobe cycle and remember when it came
    int a_vcnt = 0, a_vcyc = -1;
    int b_vcnt = 0, b_vcyc = -1;
    always @(negedge clk) begin
        if (valid_a) begin a_vcnt <= a_vcnt + 1; a_vcyc <= cyc; end
        if (valid_b) begin b_vcnt <= b_vcnt + 1; b_vcyc <= cyc; end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive one level for n clocks on line a (sel=0) or b.
    task automatic drive(input bit sel, input logic v, input int n);
        if (sel) din_b = v; else din_a = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic frame_a(input logic [7:0] d, input logic stop);
        drive(0, 1'b0, 50);
        for (int i = 0; i < 8; i++) drive(0, d[i], 50);
        drive(0, stop, 50);
    endtask

    task automatic frame_b(input logic [6:0] d, input logic p);
        drive(1, 1'b0, 16);
        for (int i = 0; i < 7; i++) drive(1, d[i], 16);
        drive(1, p, 16);
        drive(1, 1'b1, 16);
        drive(1, 1'b1, 16);
    endtask

    int c, r;
    logic [7:0] v55;

    initial begin
        rst = 1'b1; din_a = 1'b1; din_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_dout",  32'(dout_a), 32'h0);
        chk("rst_valid", 32'(valid_a), 32'h0);
        chk("rst_perr",  32'(pe_a), 32'h0);
        chk("rst_ferr",  32'(fe_a), 32'h0);
        chk("rst_busy",  32'(busy_a), 32'h0);
        chk("rst_brk",   32'(brk_a), 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // back-to-back 0xA5 / 0x3C, single stop bit
        c = cyc; frame_a(8'hA5, 1'b1);
        chk("t1_cnt0", 32'(a_vcnt), 32'd1);
        chk("t1_cyc0", 32'(a_vcyc), 32'(c + 478));
        chk("t1_dout0", 32'(dout_a), 32'hA5);
        chk("t1_perr0", 32'(pe_a), 32'h0);
        chk("t1_ferr0", 32'(fe_a), 32'h0);
        c = cyc; frame_a(8'h3C, 1'b1);
        chk("t1_cnt1", 32'(a_vcnt), 32'd2);
        chk("t1_cyc1", 32'(a_vcyc), 32'(c + 478));
        chk("t1_dout1", 32'(dout_a), 32'h3C);
        chk("t1_ferr1", 32'(fe_a), 32'h0);
        drive(0, 1'b1, 100);

        // 0x55 with stop low, line held low 3 more bit times
        v55 = 8'h55;
        c = cyc;
        drive(0, 1'b0, 50);
        for (int i = 0; i < 8; i++) drive(0, v55[i], 50);
        drive(0, 1'b0, 200);
        chk("t3_cnt",  32'(a_vcnt), 32'd3);
        chk("t3_cyc",  32'(a_vcyc), 32'(c + 478));
        chk("t3_dout", 32'(dout_a), 32'h55);
        chk("t3_ferr", 32'(fe_a), 32'h1);
        chk("t3_busy_low", 32'(busy_a), 32'h1);
        r = cyc; din_a = 1'b1;
        wait_until(r + 2);
        chk("t3_busy_r2", 32'(busy_a), 32'h1);
        wait_until(r + 3);
        chk("t3_busy_r3", 32'(busy_a), 32'h0);
        drive(0, 1'b1, 100);
        chk("t3_no_2nd", 32'(a_vcnt), 32'd3);

        // 12-cycle glitch: false start resolved at T0+25
        c = cyc;
        drive(0, 1'b0, 12);
        din_a = 1'b1;
        wait_until(c + 27);
        chk("t4_busy_27", 32'(busy_a), 32'h1);
        wait_until(c + 28);
        chk("t4_busy_28", 32'(busy_a), 32'h0);
        drive(0, 1'b1, 100);
        chk("t4_no_valid", 32'(a_vcnt), 32'd3);
        chk("t4_dout_hold", 32'(dout_a), 32'h55);

        // reset pulse during data bit 3
        drive(0, 1'b0, 50);
        for (int i = 0; i < 3; i++) drive(0, 1'b0, 50);
        drive(0, 1'b0, 20);
        rst = 1'b1; din_a = 1'b1;
        #1;
        chk("t5_dout", 32'(dout_a), 32'h0);
        chk("t5_ferr", 32'(fe_a), 32'h0);
        chk("t5_busy", 32'(busy_a), 32'h0);
        chk("t5_valid", 32'(valid_a), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b1, 600);
        chk("t5_no_valid", 32'(a_vcnt), 32'd3);
        c = cyc; frame_a(8'h81, 1'b1);
        chk("t5_cnt", 32'(a_vcnt), 32'd4);
        chk("t5_cyc", 32'(a_vcyc), 32'(c + 478));
        chk("t5_dout81", 32'(dout_a), 32'h81);
        chk("t5_ferr81", 32'(fe_a), 32'h0);
        chk("t5_brk81", 32'(brk_a), 32'h0);

        // break: line low for 12 bit times
        drive(0, 1'b1, 50);
        c = cyc;
        drive(0, 1'b0, 600);
        chk("t6_cnt",  32'(a_vcnt), 32'd5);
        chk("t6_cyc",  32'(a_vcyc), 32'(c + 478));
        chk("t6_dout", 32'(dout_a), 32'h0);
        chk("t6_ferr", 32'(fe_a), 32'h1);
        chk("t6_brk",  32'(brk_a), 32'(EXP_BRK));
        chk("t6_busy_low", 32'(busy_a), 32'h1);
        drive(0, 1'b1, 100);
        chk("t6_busy_idle", 32'(busy_a), 32'h0);
        chk("t6_cnt_after", 32'(a_vcnt), 32'd5);

        // 7E2 on instance b
        chk("t2_idle", 32'(b_vcnt), 32'd0);
        c = cyc; frame_b(7'h03, 1'b0);
        chk("t2_cnt0",  32'(b_vcnt), 32'd1);
        chk("t2_cyc0",  32'(b_vcyc), 32'(c + 171));
        chk("t2_dout0", 32'(dout_b), 32'h03);
        chk("t2_perr0", 32'(pe_b), 32'h0);
        chk("t2_ferr0", 32'(fe_b), 32'h0);
        c = cyc; frame_b(7'h07, 1'b0);
        chk("t2_cnt1",  32'(b_vcnt), 32'd2);
        chk("t2_cyc1",  32'(b_vcyc), 32'(c + 171));
        chk("t2_dout1", 32'(dout_b), 32'h07);
        chk("t2_perr1", 32'(pe_b), 32'h1);
        frame_b(7'h07, 1'b1);
        chk("t2_cnt2",  32'(b_vcnt), 32'd3);
        chk("t2_perr2", 32'(pe_b), 32'h0);
        chk("t2_ferr2", 32'(fe_b), 32'h0);
        drive(1, 1'b1, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
